// File: rtl/decode_ibuf_pkg.sv
// Shared definitions for the fetch-to-decode instruction buffer:
// opcode/funct constants used by predecode and the per-slot record type.
package decode_ibuf_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_JALR   = 6'h09;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ibuf_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        is_branch;
        logic        is_jump;
        logic        is_jr;
        logic [31:0] target;
    } dec_slot_t;

    function automatic logic is_cti(input dec_slot_t s);
        return s.is_branch | s.is_jump | s.is_jr;
    endfunction

endpackage

// File: rtl/decode_ibuf_if.sv
// Fetch/decode facing bundle of the instruction buffer; the buffer takes the
// slave view, the fetch/decode side (or a bench) takes the master view.
interface decode_ibuf_if #(
    parameter int DEPTH = 8,
    parameter int ISSUE = 2
);
    import decode_ibuf_pkg::*;

    logic                         in_valid;
    logic [31:0]                  in_pc;
    logic [31:0]                  in_instr;
    logic                         in_ready;
    logic                         flush;
    logic                         stall;
    logic [ISSUE-1:0]             out_valid;
    dec_slot_t [ISSUE-1:0]        out_slot;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output in_valid, in_pc, in_instr, flush, stall,
        input  in_ready, out_valid, out_slot, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, stall,
        output in_ready, out_valid, out_slot, count
    );

endinterface

// File: rtl/decode_ibuf_predecode.sv
// Combinational predecoder: classifies one instruction as branch, jump or
// register jump and computes its static target.
module ibuf_predecode
    import decode_ibuf_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output dec_slot_t   slot
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc4;
    logic [31:0] br_off;

    assign op     = instr[31:26];
    assign funct  = instr[5:0];
    assign pc4    = pc + 32'd4;
    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        slot           = '0;
        slot.pc        = pc;
        slot.instr     = instr;
        slot.is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
                         (op == OP_BGTZ) || (op == OP_REGIMM);
        slot.is_jump   = (op == OP_J) || (op == OP_JAL);
        slot.is_jr     = (op == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
        if (slot.is_branch) begin
            slot.target = pc4 + br_off;
        end else if (slot.is_jump) begin
            slot.target = {pc4[31:28], instr[25:0], 2'b00};
        end
    end

endmodule

// File: rtl/decode_ibuf.sv
// Circular instruction queue between fetch and decode; issues up to ISSUE
// predecoded instructions per cycle and keeps a CTI together with its delay slot.
module decode_ibuf
    import decode_ibuf_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ISSUE = 2
) (
    input  logic          clk,
    input  logic          reset,
    decode_ibuf_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    ibuf_entry_t            mem [DEPTH];
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [CW-1:0]          count_q;

    dec_slot_t [ISSUE-1:0]  slot;
    logic [ISSUE-1:0]       valid;
    logic                   ready;
    logic                   push;
    logic                   pop;
    logic [CW-1:0]          n_issue;
    logic [CW-1:0]          n_take;

    for (genvar i = 0; i < ISSUE; i++) begin : g_slot
        logic [PW-1:0] idx;
        ibuf_entry_t   ent;
        assign idx = head + PW'(i);
        assign ent = mem[idx];
        ibuf_predecode u_predecode (
            .pc    (ent.pc),
            .instr (ent.instr),
            .slot  (slot[i])
        );
    end

    // A CTI at slot0 must leave with its delay slot; a CTI at slot1 waits to become slot0.
    if (ISSUE == 1) begin : g_issue1
        assign valid = (count_q != '0);
    end else begin : g_issue2
        always_comb begin
            valid = '0;
            if (count_q >= CW'(2)) begin
                if (is_cti(slot[0]))      valid = 2'b11;
                else if (is_cti(slot[1])) valid = 2'b01;
                else                      valid = 2'b11;
            end else if (count_q == CW'(1)) begin
                valid = is_cti(slot[0]) ? 2'b00 : 2'b01;
            end
        end
    end

    always_comb begin
        n_issue = '0;
        for (int i = 0; i < ISSUE; i++) begin
            n_issue = n_issue + CW'(valid[i]);
        end
    end

    assign ready  = (count_q < CW'(DEPTH));
    assign push   = bus.in_valid && ready && !bus.flush;
    assign pop    = !bus.stall && !bus.flush;
    assign n_take = pop ? n_issue : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[tail] <= '{pc: bus.in_pc, instr: bus.in_instr};
                tail      <= tail + PW'(1);
            end
            head    <= head + PW'(n_take);
            count_q <= count_q + CW'(push) - n_take;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out_slot  = slot;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_decode_ibuf.sv
// Randomised and directed bench for decode_ibuf against a queue-based model
// of the buffer's issue and predecode rules.
module tb_decode_ibuf;
    import decode_ibuf_pkg::*;

    localparam int DEPTH = 8;
    localparam int ISSUE = 2;

    localparam logic [31:0] ALU = 32'h0022_1821;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_ibuf_if #(.DEPTH(DEPTH), .ISSUE(ISSUE)) bus ();

    decode_ibuf #(.DEPTH(DEPTH), .ISSUE(ISSUE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic [5:0] br_ops [5] = '{6'h01, 6'h04, 6'h05, 6'h06, 6'h07};

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_branch(input logic [31:0] instr);
        return instr[31:26] inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7};
    endfunction

    function automatic bit m_jump(input logic [31:0] instr);
        return instr[31:26] inside {6'd2, 6'd3};
    endfunction

    function automatic bit m_jr(input logic [31:0] instr);
        return (instr[31:26] == 6'd0) && (instr[5:0] inside {6'd8, 6'd9});
    endfunction

    function automatic bit m_cti(input logic [31:0] instr);
        return m_branch(instr) || m_jump(instr) || m_jr(instr);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc, input logic [31:0] instr);
        int off;
        if (m_branch(instr)) begin
            off = $signed(instr[15:0]) * 4;
            return pc + 32'd4 + 32'(off);
        end
        if (m_jump(instr)) return ((pc + 32'd4) & 32'hF000_0000) | (32'(instr[25:0]) * 4);
        return 32'h0;
    endfunction

    function automatic logic [1:0] m_valid();
        if (q.size() == 0) return 2'b00;
        if (m_cti(q[0].instr)) return (q.size() >= 2) ? 2'b11 : 2'b00;
        if (q.size() == 1) return 2'b01;
        if (m_cti(q[1].instr)) return 2'b01;
        return 2'b11;
    endfunction

    always @(posedge reset) q.delete();

    // Model state advances on the same edge as the DUT, using pre-edge occupancy.
    always @(posedge clk) begin
        int n;
        int sz;
        logic [1:0] ev;
        if (reset || bus.flush) begin
            q.delete();
        end else begin
            sz = q.size();
            ev = m_valid();
            n  = bus.stall ? 0 : (int'(ev[0]) + int'(ev[1]));
            for (int i = 0; i < n; i++) void'(q.pop_front());
            if (bus.in_valid && sz < DEPTH) q.push_back('{pc: bus.in_pc, instr: bus.in_instr});
        end
    end

    always @(negedge clk) begin
        logic [1:0] ev;
        ev = m_valid();
        check_output("count", 32'(bus.count), 32'(q.size()));
        check_output("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
        check_output("out_valid", 32'(bus.out_valid), 32'(ev));
        for (int i = 0; i < ISSUE; i++) begin
            if (ev[i]) begin
                check_output($sformatf("slot%0d.pc", i), bus.out_slot[i].pc, q[i].pc);
                check_output($sformatf("slot%0d.instr", i), bus.out_slot[i].instr, q[i].instr);
                check_output($sformatf("slot%0d.is_branch", i), 32'(bus.out_slot[i].is_branch), 32'(m_branch(q[i].instr)));
                check_output($sformatf("slot%0d.is_jump", i), 32'(bus.out_slot[i].is_jump), 32'(m_jump(q[i].instr)));
                check_output($sformatf("slot%0d.is_jr", i), 32'(bus.out_slot[i].is_jr), 32'(m_jr(q[i].instr)));
                check_output($sformatf("slot%0d.target", i), bus.out_slot[i].target, m_target(q[i].pc, q[i].instr));
            end
        end
    end

    task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                                  input logic st, input logic fl);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_instr = instr;
        bus.stall    = st;
        bus.flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle(input logic st);
        bus.in_valid = 1'b0;
        bus.in_pc    = 32'h0;
        bus.in_instr = 32'h0;
        bus.stall    = st;
        bus.flush    = 1'b0;
    endtask

    task automatic drain();
        go_idle(1'b0);
        for (int i = 0; i < 20 && bus.count != '0; i++) begin
            @(posedge clk);
            #1;
        end
        check_output("drain_done", 32'(bus.count), 32'h0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0:       return {br_ops[$urandom_range(0, 4)], r[25:0]};
            1:       return {($urandom_range(0, 1) == 1) ? 6'h03 : 6'h02, r[25:0]};
            2:       return {6'h00, r[25:6], ($urandom_range(0, 1) == 1) ? 6'h09 : 6'h08};
            3, 4, 5: return {6'h00, r[25:6], 6'h21};
            default: return {6'h23, r[25:0]};
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        go_idle(1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_output("reset_count", 32'(bus.count), 32'h0);
        check_output("reset_ready", 32'(bus.in_ready), 32'h1);
        check_output("reset_valid", 32'(bus.out_valid), 32'h0);

        // three straight-line instructions, then release decode
        apply_stimulus(1'b1, 32'hbfc0_0000, ALU, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'hbfc0_0004, ALU, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'hbfc0_0008, ALU, 1'b1, 1'b0);
        go_idle(1'b0);
        @(negedge clk);
        check_output("seq_valid0", 32'(bus.out_valid), 32'h3);
        check_output("seq_pc0", bus.out_slot[0].pc, 32'hbfc0_0000);
        check_output("seq_pc1", bus.out_slot[1].pc, 32'hbfc0_0004);
        @(negedge clk);
        check_output("seq_valid1", 32'(bus.out_valid), 32'h1);
        check_output("seq_pc2", bus.out_slot[0].pc, 32'hbfc0_0008);
        @(negedge clk);
        check_output("seq_empty", 32'(bus.count), 32'h0);

        // branch waits alone until its delay slot arrives
        apply_stimulus(1'b1, 32'hbfc0_0000, 32'h1000_0003, 1'b0, 1'b0);
        go_idle(1'b0);
        @(negedge clk);
        check_output("beq_alone0", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        check_output("beq_alone1", 32'(bus.out_valid), 32'h0);
        apply_stimulus(1'b1, 32'hbfc0_0004, NOP, 1'b0, 1'b0);
        go_idle(1'b0);
        @(negedge clk);
        check_output("beq_pair", 32'(bus.out_valid), 32'h3);
        check_output("beq_target", bus.out_slot[0].target, 32'hbfc0_0010);
        check_output("beq_is_branch", 32'(bus.out_slot[0].is_branch), 32'h1);
        drain();

        // non-CTI followed by a jump in slot1
        apply_stimulus(1'b1, 32'hbfc0_0100, ALU, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'hbfc0_0104, 32'h0800_0100, 1'b1, 1'b0);
        go_idle(1'b0);
        @(negedge clk);
        check_output("j_first", 32'(bus.out_valid), 32'h1);
        check_output("j_first_pc", bus.out_slot[0].pc, 32'hbfc0_0100);
        @(negedge clk);
        check_output("j_wait", 32'(bus.out_valid), 32'h0);
        check_output("j_pc", bus.out_slot[0].pc, 32'hbfc0_0104);
        check_output("j_target", bus.out_slot[0].target, 32'hb000_0400);
        check_output("j_is_jump", 32'(bus.out_slot[0].is_jump), 32'h1);
        apply_stimulus(1'b1, 32'hbfc0_0108, NOP, 1'b0, 1'b0);
        drain();

        // fill to DEPTH under stall, then release with one pending push
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 32'h0000_1000 + 32'(i * 4), ALU, 1'b1, 1'b0);
        @(negedge clk);
        check_output("full_count", 32'(bus.count), 32'h8);
        check_output("full_ready", 32'(bus.in_ready), 32'h0);
        apply_stimulus(1'b1, 32'h0000_2000, ALU, 1'b0, 1'b0);
        @(negedge clk);
        check_output("full_rejected", 32'(bus.count), 32'h6);
        apply_stimulus(1'b1, 32'h0000_2000, ALU, 1'b0, 1'b0);
        go_idle(1'b0);
        @(negedge clk);
        check_output("full_accepted", 32'(bus.count), 32'h5);
        drain();

        // flush wins over a same-cycle push
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 32'h0000_3000 + 32'(i * 4), ALU, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'h0000_3100, ALU, 1'b1, 1'b1);
        go_idle(1'b0);
        @(negedge clk);
        check_output("flush_count", 32'(bus.count), 32'h0);
        check_output("flush_valid", 32'(bus.out_valid), 32'h0);

        // asynchronous reset between edges
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 32'h0000_4000 + 32'(i * 4), ALU, 1'b1, 1'b0);
        go_idle(1'b1);
        @(negedge clk);
        check_output("pre_reset_count", 32'(bus.count), 32'h4);
        #2 reset = 1'b1;
        #1;
        check_output("async_valid", 32'(bus.out_valid), 32'h0);
        check_output("async_ready", 32'(bus.in_ready), 32'h1);
        check_output("async_count", 32'(bus.count), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, rand_instr(),
                           $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
        end
        drain();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
